// File: rtl/ctw_frame_receiver_if.sv
// Purpose: byte-stream bundle for the frame receiver (link bytes in, payload bytes out).
// Latency: none (wires only); pay_* lags the accepted rx byte by one cycle inside the receiver.
// Backpressure: none; both directions are valid-only, one byte per valid-high cycle.
//
// Signals:
//   rx_data/rx_valid   : inbound link byte, driven by the source (master)
//   pay_data/pay_valid : forwarded payload byte, driven by the receiver (slave)
interface ctw_frame_receiver_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] pay_data;
    logic       pay_valid;

    modport master (output rx_data, output rx_valid, input pay_data, input pay_valid);
    modport slave  (input rx_data, input rx_valid, output pay_data, output pay_valid);
endinterface

// File: rtl/ctw_frame_receiver.sv
// Purpose: ground-end frame receiver; hunts SYNC, parses HDR/payload/CRC-8, forwards payload, keeps stats.
// Latency: payload byte and frame_ok/frame_err/seq_err pulses appear 1 cycle after the accepted byte.
// Backpressure: none; source is never stalled, ena=0 aborts the frame back to HUNT.
//
// Ports:
//   i_clk, i_rst_n (synchronous, active-low), i_ena (block enable)
//   rx_if (slave)  : rx_data/rx_valid in, pay_data/pay_valid out
//   o_frame_ok / o_frame_err / o_seq_err : per-frame 1-cycle pulses
//   o_rx_dir / o_rx_seq : header fields of the last good frame
//   o_ok_count / o_err_count : saturating frame counters
//   o_busy : a frame is in progress (state != HUNT)
// Optional feature: define CTW_RX_SEQ_CHECK_EN to enable per-direction sequence
// continuity checking on o_seq_err; without it o_seq_err is constant 0.
module ctw_frame_receiver #(
    parameter int unsigned PAYLOAD_LEN = 4,
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ena,
    ctw_frame_receiver_if.slave rx_if,
    output logic                o_frame_ok,
    output logic                o_frame_err,
    output logic                o_seq_err,
    output logic                o_rx_dir,
    output logic [3:0]          o_rx_seq,
    output logic [7:0]          o_ok_count,
    output logic [7:0]          o_err_count,
    output logic                o_busy
);

    typedef enum logic [1:0] {ST_HUNT, ST_HDR, ST_PAY, ST_CRC} state_t;

    localparam logic [3:0] IDX_LAST  = 4'(PAYLOAD_LEN - 1);
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

    // CRC-8, poly 0x07, MSB first, one byte per call.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    state_t     r_state;
    logic [7:0] r_crc;
    logic [3:0] r_idx;
    logic [7:0] r_idle;
    logic       r_hdr_dir;
    logic [3:0] r_hdr_seq;
    logic [7:0] r_pay_data;
    logic       r_pay_valid;
    logic       r_frame_ok;
    logic       r_frame_err;
    logic       r_rx_dir;
    logic [3:0] r_rx_seq;
    logic [7:0] r_ok_count;
    logic [7:0] r_err_count;

    state_t     w_state_nxt;
    logic [7:0] w_crc_nxt;
    logic [3:0] w_idx_nxt;
    logic       w_accept;
    logic       w_hdr_load;
    logic       w_pay_fwd;
    logic       w_ok;
    logic       w_err;

    assign w_accept = rx_if.rx_valid & i_ena;

    always_comb begin
        w_state_nxt = r_state;
        w_crc_nxt   = r_crc;
        w_idx_nxt   = r_idx;
        w_hdr_load  = 1'b0;
        w_pay_fwd   = 1'b0;
        w_ok        = 1'b0;
        w_err       = 1'b0;

        if (!i_ena) begin
            w_state_nxt = ST_HUNT;
        end else if (w_accept) begin
            case (r_state)
                ST_HUNT: begin
                    // SYNC is only a start marker here; inside a frame it is plain data.
                    if (rx_if.rx_data == SYNC_BYTE) begin
                        w_state_nxt = ST_HDR;
                        w_crc_nxt   = 8'h00;
                    end
                end
                ST_HDR: begin
                    w_hdr_load = 1'b1;
                    w_crc_nxt  = crc8_step(r_crc, rx_if.rx_data);
                    if (rx_if.rx_data[6:4] != 3'b000) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_HUNT;
                    end else begin
                        w_state_nxt = ST_PAY;
                        w_idx_nxt   = 4'd0;
                    end
                end
                ST_PAY: begin
                    w_pay_fwd = 1'b1;
                    w_crc_nxt = crc8_step(r_crc, rx_if.rx_data);
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_CRC;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
                ST_CRC: begin
                    if (rx_if.rx_data == r_crc) begin
                        w_ok = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                    w_state_nxt = ST_HUNT;
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end else if (r_state != ST_HUNT && r_idle == IDLE_LAST) begin
            // This idle cycle is the TIMEOUT-th one since the last accepted byte.
            w_err       = 1'b1;
            w_state_nxt = ST_HUNT;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_HUNT;
            r_crc       <= 8'h00;
            r_idx       <= 4'd0;
            r_idle      <= 8'd0;
            r_hdr_dir   <= 1'b0;
            r_hdr_seq   <= 4'd0;
            r_pay_data  <= 8'h00;
            r_pay_valid <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_dir    <= 1'b0;
            r_rx_seq    <= 4'd0;
            r_ok_count  <= 8'd0;
            r_err_count <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_crc       <= w_crc_nxt;
            r_idx       <= w_idx_nxt;
            r_pay_valid <= w_pay_fwd;
            r_frame_ok  <= w_ok;
            r_frame_err <= w_err;

            // Idle counter only runs while a frame is open and nothing arrives.
            if (!i_ena || w_accept || w_state_nxt == ST_HUNT) begin
                r_idle <= 8'd0;
            end else begin
                r_idle <= r_idle + 8'd1;
            end

            if (w_pay_fwd) begin
                r_pay_data <= rx_if.rx_data;
            end
            if (w_hdr_load) begin
                r_hdr_dir <= rx_if.rx_data[7];
                r_hdr_seq <= rx_if.rx_data[3:0];
            end
            if (w_ok) begin
                r_rx_dir <= r_hdr_dir;
                r_rx_seq <= r_hdr_seq;
                if (r_ok_count != 8'hFF) begin
                    r_ok_count <= r_ok_count + 8'd1;
                end
            end
            if (w_err && r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

`ifdef CTW_RX_SEQ_CHECK_EN
    logic [3:0] r_last_seq_ul;
    logic [3:0] r_last_seq_dl;
    logic       r_last_vld_ul;
    logic       r_last_vld_dl;
    logic       r_seq_err;
    logic [3:0] w_exp_seq;
    logic       w_last_vld;

    // r_hdr_* still holds the header of the frame whose CRC is being judged.
    always_comb begin
        w_exp_seq  = (r_hdr_dir ? r_last_seq_dl : r_last_seq_ul) + 4'd1;
        w_last_vld = r_hdr_dir ? r_last_vld_dl : r_last_vld_ul;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last_seq_ul <= 4'd0;
            r_last_seq_dl <= 4'd0;
            r_last_vld_ul <= 1'b0;
            r_last_vld_dl <= 1'b0;
            r_seq_err     <= 1'b0;
        end else begin
            r_seq_err <= 1'b0;
            if (w_ok) begin
                r_seq_err <= w_last_vld && (r_hdr_seq != w_exp_seq);
                if (r_hdr_dir) begin
                    r_last_seq_dl <= r_hdr_seq;
                    r_last_vld_dl <= 1'b1;
                end else begin
                    r_last_seq_ul <= r_hdr_seq;
                    r_last_vld_ul <= 1'b1;
                end
            end
        end
    end

    assign o_seq_err = r_seq_err;
`else
    assign o_seq_err = 1'b0;
`endif

    assign rx_if.pay_data  = r_pay_data;
    assign rx_if.pay_valid = r_pay_valid;
    assign o_frame_ok      = r_frame_ok;
    assign o_frame_err     = r_frame_err;
    assign o_rx_dir        = r_rx_dir;
    assign o_rx_seq        = r_rx_seq;
    assign o_ok_count      = r_ok_count;
    assign o_err_count     = r_err_count;
    assign o_busy          = (r_state != ST_HUNT);

endmodule

// File: tb/tb_ctw_frame_receiver.sv
// Testbench for ctw_frame_receiver: frame-level reference model feeds expectation
// queues; an independent negedge monitor pops and compares payload bytes and frame events.
module tb_ctw_frame_receiver;

    localparam int         PLEN    = 4;
    localparam int         TMO     = 255;
    localparam logic [7:0] SYNC    = 8'hA5;

    typedef struct packed {
        logic       ok;
        logic       err;
        logic       se;
        logic       dir;
        logic [3:0] seq;
        logic [7:0] okc;
        logic [7:0] errc;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       frame_ok, frame_err, seq_err, rx_dir, busy;
    logic [3:0] rx_seq;
    logic [7:0] ok_count, err_count;

    ctw_frame_receiver_if rx_if ();

    ctw_frame_receiver #(.PAYLOAD_LEN(PLEN), .TIMEOUT(TMO), .SYNC_BYTE(SYNC)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ena       (ena),
        .rx_if       (rx_if),
        .o_frame_ok  (frame_ok),
        .o_frame_err (frame_err),
        .o_seq_err   (seq_err),
        .o_rx_dir    (rx_dir),
        .o_rx_seq    (rx_seq),
        .o_ok_count  (ok_count),
        .o_err_count (err_count),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;

    logic [7:0] pay_q[$];
    ev_t        ev_q[$];

    // Reference model state (frame-level view)
    int         m_ok, m_err;
    logic       m_dir;
    logic [3:0] m_seq;
    logic       m_lvld [2];
    logic [3:0] m_lseq [2];
    logic [7:0] fr_pay [PLEN];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Bit-serial CRC-8 (poly 0x07, MSB first): each message bit enters the register.
    function automatic logic [7:0] crc_ser(input logic [7:0] c_in, input logic [7:0] b);
        logic [7:0] c;
        logic       fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ b[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    function automatic void model_reset();
        m_ok = 0; m_err = 0; m_dir = 1'b0; m_seq = 4'd0;
        for (int i = 0; i < 2; i++) begin m_lvld[i] = 1'b0; m_lseq[i] = 4'd0; end
    endfunction

    function automatic void model_ok(input logic dir, input logic [3:0] seq);
        logic se;
        int   d;
        se = 1'b0;
        d  = dir ? 1 : 0;
`ifdef CTW_RX_SEQ_CHECK_EN
        se = m_lvld[d] && (int'(seq) != (int'(m_lseq[d]) + 1) % 16);
`endif
        m_lvld[d] = 1'b1;
        m_lseq[d] = seq;
        m_dir = dir;
        m_seq = seq;
        if (m_ok < 255) m_ok++;
        ev_q.push_back('{1'b1, 1'b0, se, m_dir, m_seq, 8'(m_ok), 8'(m_err)});
    endfunction

    function automatic void model_err();
        if (m_err < 255) m_err++;
        ev_q.push_back('{1'b0, 1'b1, 1'b0, m_dir, m_seq, 8'(m_ok), 8'(m_err)});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) tick();
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        tick();
        rx_if.rx_valid = 1'b0;
    endtask

    function automatic int rgap(input int max_gap);
        return (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
    endfunction

    // Sends SYNC | hdr | fr_pay | crc^flip and records what the receiver must report.
    task automatic send_frame(input logic [7:0] hdr, input logic [7:0] flip, input int max_gap);
        logic [7:0] crc;
        send_byte(SYNC, rgap(max_gap));
        if (hdr[6:4] != 3'd0) begin
            model_err();
            send_byte(hdr, rgap(max_gap));
            return;
        end
        send_byte(hdr, rgap(max_gap));
        crc = crc_ser(8'h00, hdr);
        for (int k = 0; k < PLEN; k++) begin
            crc = crc_ser(crc, fr_pay[k]);
            pay_q.push_back(fr_pay[k]);
            send_byte(fr_pay[k], rgap(max_gap));
        end
        if (flip == 8'h00) model_ok(hdr[7], hdr[3:0]);
        else               model_err();
        send_byte(crc ^ flip, rgap(max_gap));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx_if.rx_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: pops expectations whenever the DUT presents an output.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rx_if.pay_valid === 1'b1) begin
                if (pay_q.size() == 0) chk("pay_unexpected", {24'd0, rx_if.pay_data}, 32'hFFFF_FFFF);
                else chk("pay_data", {24'd0, rx_if.pay_data}, {24'd0, pay_q.pop_front()});
            end
            if (frame_ok === 1'b1 || frame_err === 1'b1) begin
                ev_t act;
                act = '{frame_ok, frame_err, seq_err, rx_dir, rx_seq, ok_count, err_count};
                if (ev_q.size() == 0) chk("event_unexpected", {8'd0, act}, 32'hFFFF_FFFF);
                else chk("frame_event", {8'd0, act}, {8'd0, ev_q.pop_front()});
            end else if (seq_err !== 1'b0) begin
                chk("seq_err_stray", {31'd0, seq_err}, 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hdr, b, flip;
        rst_n = 1'b0; ena = 1'b1;
        rx_if.rx_data = 8'h00; rx_if.rx_valid = 1'b0;
        model_reset();
        tick(); tick(); tick();
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Reset state
        chk("reset_pulses", {28'd0, rx_if.pay_valid, frame_ok, frame_err, seq_err}, 32'd0);
        chk("reset_status", {19'd0, rx_dir, rx_seq, busy}, 32'd0);
        chk("reset_counts", {16'd0, ok_count, err_count}, 32'd0);

        // Back-to-back good frame, all-zero payload, CRC 0x62
        for (int k = 0; k < PLEN; k++) fr_pay[k] = 8'h00;
        send_frame(8'h01, 8'h00, 0);
        tick();
        chk("ok_count_after_good", {24'd0, ok_count}, 32'd1);

        // Same frame with CRC 0x63
        send_frame(8'h01, 8'h01, 0);
        chk("busy_after_crc_err", {31'd0, busy}, 32'd0);
        tick();
        chk("counts_after_crc_err", {16'd0, ok_count, err_count}, {16'd0, 8'd1, 8'd1});

        // Timeout: SYNC then silence; error exactly at the TMO-th idle cycle
        model_err();
        send_byte(SYNC, 0);
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("busy_before_timeout", {31'd0, busy}, 32'd1);
        tick();
        chk("busy_after_timeout", {31'd0, busy}, 32'd0);
        for (int k = 0; k < PLEN; k++) fr_pay[k] = 8'(k * 17 + 3);
        send_frame(8'h84, 8'h00, 1);

        // Junk before SYNC, SYNC value inside payload is data
        send_byte(8'h00, 0);
        send_byte(8'h5A, 1);
        fr_pay[0] = SYNC; fr_pay[1] = 8'h11; fr_pay[2] = SYNC; fr_pay[3] = 8'h22;
        send_frame(8'h02, 8'h00, 0);

        // Reserved bits set
        send_frame(8'h45, 8'h00, 0);

        // ena=0 mid-payload: abort without pulses, counters held
        send_byte(SYNC, 0);
        send_byte(8'h83, 0);
        pay_q.push_back(8'hC1); send_byte(8'hC1, 0);
        pay_q.push_back(8'hC2); send_byte(8'hC2, 0);
        ena = 1'b0;
        tick();
        chk("busy_after_ena_low", {31'd0, busy}, 32'd0);
        chk("pulses_ena_low", {28'd0, rx_if.pay_valid, frame_ok, frame_err, seq_err}, 32'd0);
        tick();
        chk("counts_ena_low", {16'd0, ok_count, err_count}, {16'd0, 8'(m_ok), 8'(m_err)});
        ena = 1'b1;

        // Reset mid-frame, then sequence continuity UL seq 1 -> UL seq 3
        send_byte(SYNC, 0);
        send_byte(8'h07, 0);
        pay_q.push_back(8'h99); send_byte(8'h99, 0);
        chk("queues_before_reset", {pay_q.size(), ev_q.size()}, 32'd0);
        do_reset();
        chk("busy_after_reset", {31'd0, busy}, 32'd0);
        chk("counts_after_reset", {16'd0, ok_count, err_count}, 32'd0);
        for (int k = 0; k < PLEN; k++) fr_pay[k] = 8'(32 + k);
        send_frame(8'h01, 8'h00, 0);
        send_frame(8'h03, 8'h00, 0);
        send_frame(8'h85, 8'h00, 1);
        send_frame(8'h86, 8'h00, 1);

        // Randomized frames with junk and inter-byte gaps
        for (int f = 0; f < 40; f++) begin
            int nj;
            nj = int'($urandom_range(0, 2));
            for (int j = 0; j < nj; j++) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h3C;
                send_byte(b, rgap(2));
            end
            hdr = 8'($urandom);
            if ($urandom_range(0, 7) != 0) hdr[6:4] = 3'd0;
            for (int k = 0; k < PLEN; k++) fr_pay[k] = 8'($urandom);
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_frame(hdr, flip, 3);
        end

        // Error counter saturation
        for (int i = 0; i < 260; i++) send_frame(8'h10, 8'h00, 0);
        tick(); tick();
        chk("err_count_saturated", {24'd0, err_count}, 32'd255);
        for (int k = 0; k < PLEN; k++) fr_pay[k] = 8'h5A;
        send_frame(8'h0C, 8'h00, 0);

        tick(); tick(); tick();
        chk("pay_q_drained", pay_q.size(), 32'd0);
        chk("ev_q_drained", ev_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
